// File: rtl/bilineal_pkg.sv
// bilineal_pkg
// Shared types and default widths for the bilinear fetch controller.
//   state_t  : fetch sequencer FSM states
//   pix_t    : one 8-bit pixel
//   window_t : the 2x2 neighbourhood returned to the interpolator
package bilineal_pkg;

    localparam int DEF_COORD_W = 8;
    localparam int DEF_ADDR_W  = 12;

    typedef logic [7:0] pix_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST,
        ST_HOLD
    } state_t;

    typedef struct packed {
        pix_t p00;
        pix_t p01;
        pix_t p10;
        pix_t p11;
    } window_t;

endpackage

// File: rtl/bilineal_addr_gen.sv
// bilineal_addr_gen
// Combinational edge clamp and RAM address generation for one 2x2 window.
// Ports:
//   x, y        : requested top-left coordinate
//   w, h        : image dimensions (0 behaves as 1)
//   base        : RAM address of pixel (0,0)
//   addr00..11  : addresses of (xc,yc), (x1,yc), (xc,y1), (x1,y1)
//   clamped     : request fell outside the image and was clamped
module bilineal_addr_gen
    import bilineal_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    input  logic [ADDR_W-1:0]  base,
    output logic [ADDR_W-1:0]  addr00,
    output logic [ADDR_W-1:0]  addr01,
    output logic [ADDR_W-1:0]  addr10,
    output logic [ADDR_W-1:0]  addr11,
    output logic               clamped
);

    logic [COORD_W-1:0] w_eff, h_eff, x_max, y_max, xc, yc, x1, y1;

    // Arithmetic mod 2^ADDR_W gives the same result as computing at full
    // width and truncating, so addresses wrap naturally.
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [ADDR_W-1:0]  b,
        input logic [COORD_W-1:0] row,
        input logic [COORD_W-1:0] col,
        input logic [COORD_W-1:0] width
    );
        return b + ADDR_W'(row) * ADDR_W'(width) + ADDR_W'(col);
    endfunction

    always_comb begin
        w_eff   = (w == '0) ? COORD_W'(1) : w;
        h_eff   = (h == '0) ? COORD_W'(1) : h;
        x_max   = w_eff - COORD_W'(1);
        y_max   = h_eff - COORD_W'(1);
        xc      = (x > x_max) ? x_max : x;
        yc      = (y > y_max) ? y_max : y;
        // The right/bottom neighbour replicates the edge pixel.
        x1      = (xc == x_max) ? xc : xc + COORD_W'(1);
        y1      = (yc == y_max) ? yc : yc + COORD_W'(1);
        clamped = (x > x_max) | (y > y_max);
        addr00  = pix_addr(base, yc, xc, w_eff);
        addr01  = pix_addr(base, yc, x1, w_eff);
        addr10  = pix_addr(base, y1, xc, w_eff);
        addr11  = pix_addr(base, y1, x1, w_eff);
    end

endmodule

// File: rtl/bilineal_fetch_ctrl.sv
// bilineal_fetch_ctrl
// Read sequencer for the 8-bit pixel RAM (registered read, 1-cycle latency).
// Accepts a coordinate, reads p00, p01, p10, p11 and presents the 2x2 window.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   img_w, img_h, base_addr    : image geometry, sampled at acceptance
//   req_valid/req_ready        : coordinate request handshake (req_x, req_y)
//   mem_raddr, mem_rdata       : RAM read port
//   out_valid/out_ready        : window handshake (out_p00..out_p11, out_clamped)
//   busy                       : sequencer not idle
//   stat_req_cnt/stat_stall_cnt: saturating statistics
// Build option: define FETCH_STATS_EN to implement the statistics counters;
// otherwise both statistics ports read 0.
module bilineal_fetch_ctrl
    import bilineal_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] img_w,
    input  logic [COORD_W-1:0] img_h,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic [7:0]         mem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_p00,
    output logic [7:0]         out_p01,
    output logic [7:0]         out_p10,
    output logic [7:0]         out_p11,
    output logic               out_clamped,
    output logic               busy,
    output logic [15:0]        stat_req_cnt,
    output logic [15:0]        stat_stall_cnt
);

    logic [ADDR_W-1:0] gen_a00, gen_a01, gen_a10, gen_a11;
    logic              gen_clamped;

    bilineal_addr_gen #(
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W)
    ) u_addr_gen (
        .x       (req_x),
        .y       (req_y),
        .w       (img_w),
        .h       (img_h),
        .base    (base_addr),
        .addr00  (gen_a00),
        .addr01  (gen_a01),
        .addr10  (gen_a10),
        .addr11  (gen_a11),
        .clamped (gen_clamped)
    );

    state_t                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [3:0][ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0]      raddr_q, raddr_d;
    window_t                win_q, win_d;
    logic                   clamped_q, clamped_d;
    logic                   valid_q, valid_d;
    logic                   accept;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Next-state logic. The read address is registered one step ahead so
    // that it is on the bus during FETCH idx 0..3; data for idx-1 returns
    // one cycle later and is captured into its window slot.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        raddr_d   = '0;
        win_d     = win_q;
        clamped_d = clamped_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d    = {gen_a11, gen_a10, gen_a01, gen_a00};
                    clamped_d = gen_clamped;
                    idx_d     = 2'd0;
                    raddr_d   = gen_a00;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                case (idx_q)
                    2'd1:    win_d.p00 = mem_rdata;
                    2'd2:    win_d.p01 = mem_rdata;
                    2'd3:    win_d.p10 = mem_rdata;
                    default: ;
                endcase
                if (idx_q == 2'd3) begin
                    state_d = ST_LAST;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    raddr_d = addr_q[idx_q + 2'd1];
                end
            end
            ST_LAST: begin
                win_d.p11 = mem_rdata;
                valid_d   = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset discards any partially fetched window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            addr_q    <= '0;
            raddr_q   <= '0;
            win_q     <= '0;
            clamped_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            raddr_q   <= raddr_d;
            win_q     <= win_d;
            clamped_q <= clamped_d;
            valid_q   <= valid_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign mem_raddr   = raddr_q;
    assign out_valid   = valid_q;
    assign out_p00     = win_q.p00;
    assign out_p01     = win_q.p01;
    assign out_p10     = win_q.p10;
    assign out_p11     = win_q.p11;
    assign out_clamped = clamped_q;

`ifdef FETCH_STATS_EN
    logic [15:0] req_cnt_q, req_cnt_d, stall_cnt_q, stall_cnt_d;

    // Saturating counters; they clear only on reset.
    always_comb begin
        req_cnt_d   = req_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && req_cnt_q != 16'hFFFF)
            req_cnt_d = req_cnt_q + 16'd1;
        if (state_q == ST_HOLD && !out_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            req_cnt_q   <= req_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_req_cnt   = req_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`else
    logic unused_accept;
    assign unused_accept  = accept;
    assign stat_req_cnt   = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule
